pattern_tx: RTL and testbench
=============================

# pattern_tx

Serial pattern transmitter: the sending end of the single-bit `d`/`valid` stream consumed by the serial pattern detector. It accepts parallel words through a valid/ready handshake and serializes them MSB first onto `d_o`/`valid_o`. It also keeps an exact count of pattern occurrences in the emitted stream, which benches use as the expected value for the detector's `pattern` pulses. It sits between stimulus or traffic logic and the detector input.

## Interface
- `WORD_W`, 8: width of each parallel input word (≥2).
- `PAT_W`, 4: pattern length in bits (2..WORD_W).
- `PAT`, 4'b1011: pattern to count; bit `PAT_W-1` is the first bit on the wire.
- `CNT_W`, 16: width of the occurrence counter.

- `clk`  in  1: clock; all logic is on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `word_i`  in  WORD_W: word to transmit.
- `word_valid_i`  in  1: `word_i` is valid.
- `word_ready_o`  out  1: the transmitter can accept a word this cycle (combinational).
- `d_o`  out  1: serial data bit (registered).
- `valid_o`  out  1: `d_o` is valid (registered).
- `busy_o`  out  1: a word is being shifted out.
- `clr_cnt_i`  in  1: synchronous clear of `pat_cnt_o`.
- `pat_cnt_o`  out  CNT_W: pattern occurrences emitted so far (saturating).

## Operation
- FSM states are IDLE and SHIFT.
  - IDLE → SHIFT on accept.
  - SHIFT → IDLE after the last bit, unless a new word is accepted on that same cycle.
- Accept occurs when `word_valid_i && word_ready_o`.
- `word_ready_o` is high in IDLE, or in SHIFT when the remaining-bit count is 0 (last bit on the wire). It is low while `rst` is high.
- On accept:
  - `d_o` ← `word_i[WORD_W-1]` and `valid_o` ← 1.
  - The shift register ← `word_i[WORD_W-2:0]`.
  - The remaining count ← `WORD_W-1`.
- Each SHIFT cycle with remaining count > 0: `d_o` ← next MSB, count decrements.
- With no accept pending after the last bit: `valid_o` ← 0 and `d_o` ← 0.
- `busy_o` = (state == SHIFT).
- Matching:
  - The history register holds the last `PAT_W-1` valid emitted bits.
  - A match occurs when `valid_o` is high and {history, `d_o`} == `PAT`.
  - History shifts only when `valid_o` is high. It persists across idle gaps and word boundaries.
  - Overlapping matches count.
- Counter:
  - Increments by 1 per match.
  - Saturates at 2^CNT_W−1 with no wrap.
  - `clr_cnt_i` has priority over a simultaneous match: the result is 0, not 1.
- `word_i` is sampled only on accept. Changes while `word_ready_o` is low are ignored.

## Timing
- Reset values: `d_o`=0, `valid_o`=0, `busy_o`=0, `pat_cnt_o`=0, history=0, state=IDLE.
- Reset mid-word aborts the word. `valid_o` is 0 in the cycle after the reset edge, and no partial bits resume.
- Latency: a word accepted at edge N appears as bits `WORD_W-1`..0 in the cycles after edges N..N+WORD_W−1.
- `valid_o` is high for exactly `WORD_W` consecutive cycles per word.
- Back-to-back words, with `word_valid_i` held high, produce continuous `valid_o` with no gap. Throughput is 1 word per `WORD_W` cycles.
- A match completed by the bit on `d_o` in cycle C shows on `pat_cnt_o` in cycle C+1.
- The history and counter are independent of the handshake.

## Structure
- Shared package `pattern_pkg`:
  - State enum `tx_state_t` {IDLE, SHIFT}.
  - Default constants `PAT_DEFAULT`=4'b1011 and `PAT_W_DEFAULT`=4.
  - The detector uses the same constants.
- Sub-module `pattern_match_cnt`:
  - Contains the history register, compare logic, and saturating counter.
  - Inputs: `clk`, `rst`, `bit_i`, `valid_i`, `clr_i`. Output: `cnt_o`.
  - Reusable as the bench's reference model for the detector.
- The top level holds the FSM, shift register, and handshake.

## Test plan
- Defaults; send `8'hB0` once → `d_o` = 1,0,1,1,0,0,0,0 over 8 cycles with `valid_o` high 8 cycles. `pat_cnt_o`=1 one cycle after the 4th bit. `word_ready_o` low for cycles 1–7 of the word.
- Overlap: send `8'b10110110` → `pat_cnt_o`=2.
- Cross-word boundary: send `8'h05` then `8'h80` back-to-back → `valid_o` high 16 consecutive cycles, `pat_cnt_o`=1.
- Idle gap: send `8'h01`, idle 5 cycles, then send `8'h60` → history preserved across the gap, `pat_cnt_o`=1.
- `CNT_W`=2; send 4 words of `8'hB0` → `pat_cnt_o` sticks at 3. Then assert `clr_cnt_i` on the same cycle as a match → `pat_cnt_o`=0.
- Assert `rst` at bit 3 of `8'hFF` → next cycle all outputs are 0 and `word_ready_o` is low during reset. After reset is released, a new word transmits normally from its MSB.

Source files
------------

// File: rtl/pattern_pkg.sv
// Shared definitions for the serial pattern transmitter and detector.
package pattern_pkg;

    // Pattern used by both ends of the serial link.
    localparam int unsigned PAT_W_DEFAULT = 4;
    localparam logic [PAT_W_DEFAULT-1:0] PAT_DEFAULT = 4'b1011;

    // Legacy state encodings; the enum is tied to them so old encodings stay valid.
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    typedef enum logic [0:0] {
        IDLE  = ST_IDLE,
        SHIFT = ST_SHIFT
    } tx_state_t;

    // Width of a down-counter that must hold values 0..n-1.
    function automatic int unsigned rem_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pattern_match_cnt.sv
// Pattern occurrence counter for a single-bit valid-qualified stream.
// Keeps the last PAT_W-1 valid bits, compares them with the current bit
// against PAT, and counts matches with saturation. Overlaps count.
module pattern_match_cnt
    import pattern_pkg::*;
#(
    parameter int unsigned           PAT_W = PAT_W_DEFAULT,
    parameter logic [PAT_W-1:0]      PAT   = PAT_DEFAULT,
    parameter int unsigned           CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_i,
    input  logic             valid_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [PAT_W-2:0] hist;
    logic [PAT_W-1:0] window;
    logic             match;

    // Window formed by the stored history followed by the bit on the wire now.
    always_comb begin
        window = {hist, bit_i};
        match  = valid_i && (window == PAT);
    end

    // History advances only on valid bits, so idle gaps do not disturb it.
    always_ff @(posedge clk) begin
        if (rst) begin
            hist <= '0;
        end else if (valid_i) begin
            hist <= window[PAT_W-2:0];
        end
    end

    // Saturating occurrence counter; clear wins over a simultaneous match.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_o <= '0;
        end else if (clr_i) begin
            cnt_o <= '0;
        end else if (match && (cnt_o != '1)) begin
            cnt_o <= cnt_o + 1'b1;
        end
    end

endmodule

// File: rtl/pattern_tx.sv
// Serial pattern transmitter: accepts parallel words over valid/ready and
// shifts them out MSB first on d_o/valid_o, counting pattern occurrences
// in the emitted stream.
module pattern_tx
    import pattern_pkg::*;
#(
    parameter int unsigned      WORD_W = 8,
    parameter int unsigned      PAT_W  = PAT_W_DEFAULT,
    parameter logic [PAT_W-1:0] PAT    = PAT_DEFAULT,
    parameter int unsigned      CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] word_i,
    input  logic              word_valid_i,
    output logic              word_ready_o,
    output logic              d_o,
    output logic              valid_o,
    output logic              busy_o,
    input  logic              clr_cnt_i,
    output logic [CNT_W-1:0]  pat_cnt_o
);

    localparam int unsigned REM_W = rem_width(WORD_W);

    tx_state_t         state;
    logic [WORD_W-2:0] sreg;
    logic [REM_W-1:0]  rem;
    logic              accept;

    // Ready while idle or while the final bit of the current word is on the
    // wire, which lets back-to-back words stream with no gap.
    always_comb begin
        word_ready_o = !rst && ((state == IDLE) || (rem == '0));
        accept       = word_valid_i && word_ready_o;
        busy_o       = (state == SHIFT);
    end

    // Handshake FSM and MSB-first shifter; the MSB goes straight to d_o on
    // accept, so the shift register only holds the remaining WORD_W-1 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            sreg    <= '0;
            rem     <= '0;
            d_o     <= 1'b0;
            valid_o <= 1'b0;
        end else if (accept) begin
            state   <= SHIFT;
            d_o     <= word_i[WORD_W-1];
            valid_o <= 1'b1;
            sreg    <= word_i[WORD_W-2:0];
            rem     <= REM_W'(WORD_W - 1);
        end else if (state == SHIFT) begin
            if (rem != '0) begin
                d_o  <= sreg[WORD_W-2];
                sreg <= sreg << 1;
                rem  <= rem - 1'b1;
            end else begin
                state   <= IDLE;
                d_o     <= 1'b0;
                valid_o <= 1'b0;
            end
        end
    end

    pattern_match_cnt #(
        .PAT_W (PAT_W),
        .PAT   (PAT),
        .CNT_W (CNT_W)
    ) u_match (
        .clk     (clk),
        .rst     (rst),
        .bit_i   (d_o),
        .valid_i (valid_o),
        .clr_i   (clr_cnt_i),
        .cnt_o   (pat_cnt_o)
    );

endmodule

// File: tb/tb_pattern_tx.sv
// Scoreboard bench for pattern_tx: the driver queues the expected serial bits
// of each accepted word, the monitor pops and compares them and tracks the
// expected pattern count from the bit stream. Two instances share stimulus:
// default counter width, and a 2-bit counter to exercise saturation.
module tb_pattern_tx;

    localparam int WORD_W = 8;
    localparam int PAT_W  = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] word_i = '0;
    logic       word_valid_i = 1'b0;
    logic       clr_cnt_i = 1'b0;

    logic        ready_a, d_a, valid_a, busy_a;
    logic [15:0] cnt_a;
    logic        ready_b, d_b, valid_b, busy_b;
    logic [1:0]  cnt_b;

    always #5 clk = ~clk;

    pattern_tx #(.WORD_W(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .word_i(word_i), .word_valid_i(word_valid_i),
        .word_ready_o(ready_a), .d_o(d_a), .valid_o(valid_a), .busy_o(busy_a),
        .clr_cnt_i(clr_cnt_i), .pat_cnt_o(cnt_a)
    );

    pattern_tx #(.WORD_W(8), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .word_i(word_i), .word_valid_i(word_valid_i),
        .word_ready_o(ready_b), .d_o(d_b), .valid_o(valid_b), .busy_o(busy_b),
        .clr_cnt_i(clr_cnt_i), .pat_cnt_o(cnt_b)
    );

    int     n_checks = 0;
    int     n_fail   = 0;
    int     exp_q[$];      // expected serial bits still to appear
    int     stream[$];     // most recent emitted bits (model history)
    longint raw = 0;       // unsaturated expected occurrence count
    bit     acc_last;
    logic [3:0] pat_v = 4'b1011;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: compares every cycle at the falling edge, then advances the model.
    initial begin : monitor
        int  exp_d, exp_v;
        bit  m;
        longint sat16, sat2;
        for (int i = 0; i < PAT_W - 1; i++) stream.push_back(0);
        forever begin
            @(negedge clk);
            sat16 = (raw > 65535) ? 65535 : raw;
            sat2  = (raw > 3) ? 3 : raw;
            chk("pat_cnt", cnt_a, sat16);
            chk("pat_cnt_sat", cnt_b, sat2);
            chk("word_ready", ready_a, (!rst && exp_q.size() <= 1));
            chk("word_ready_sat", ready_b, (!rst && exp_q.size() <= 1));
            chk("busy", busy_a, (exp_q.size() > 0));
            if (exp_q.size() > 0) begin
                exp_v = 1;
                exp_d = exp_q.pop_front();
            end else begin
                exp_v = 0;
                exp_d = 0;
            end
            chk("valid", valid_a, exp_v);
            chk("d", d_a, exp_d);
            chk("valid_sat", valid_b, exp_v);
            chk("d_sat", d_b, exp_d);

            m = 0;
            if (exp_v == 1) begin
                stream.push_back(exp_d);
                if (stream.size() > PAT_W) void'(stream.pop_front());
                m = 1;
                for (int k = 0; k < PAT_W; k++)
                    if (stream[stream.size() - PAT_W + k] != int'(pat_v[PAT_W-1-k])) m = 0;
            end
            if (rst) begin
                raw = 0;
                stream.delete();
                for (int i = 0; i < PAT_W - 1; i++) stream.push_back(0);
            end else if (clr_cnt_i) begin
                raw = 0;
            end else if (m) begin
                raw++;
            end
        end
    end

    // One clock: decide accept at the falling edge, record it after the rising edge.
    task automatic cycle();
        bit acc, r;
        @(negedge clk);
        acc = word_valid_i && ready_a && !rst;
        r   = rst;
        @(posedge clk);
        if (r) exp_q.delete();
        if (acc)
            for (int b = WORD_W - 1; b >= 0; b--) exp_q.push_back(int'(word_i[b]));
        acc_last = acc;
        #1;
    endtask

    task automatic idle(input int n);
        word_valid_i = 1'b0;
        for (int i = 0; i < n; i++) begin
            word_i = 8'($urandom);
            cycle();
        end
    endtask

    // Present a word until accepted; keep=1 leaves valid high for a follow-on word.
    task automatic send(input logic [7:0] w, input bit keep);
        int t = 0;
        word_i       = w;
        word_valid_i = 1'b1;
        acc_last     = 1'b0;
        while (!acc_last && t < 50) begin
            cycle();
            t++;
        end
        chk("accept_within_bound", acc_last, 1);
        if (!keep) word_valid_i = 1'b0;
    endtask

    initial begin : driver
        bit keep;
        repeat (3) cycle();
        rst = 1'b0;
        idle(2);

        // Single word carrying one occurrence.
        send(8'hB0, 0);
        idle(10);
        // Overlapping occurrences.
        send(8'b10110110, 0);
        idle(10);
        // Occurrence spanning a word boundary, back-to-back words.
        send(8'h05, 1);
        send(8'h80, 0);
        idle(10);
        // Occurrence spanning an idle gap.
        send(8'h01, 0);
        idle(5);
        send(8'h60, 0);
        idle(10);

        // Saturation of the 2-bit counter, then clear colliding with a match.
        repeat (4) send(8'hB0, 0);
        idle(10);
        send(8'hB0, 0);
        repeat (3) cycle();
        clr_cnt_i = 1'b1;
        cycle();
        clr_cnt_i = 1'b0;
        @(negedge clk);
        chk("clr_beats_match", cnt_a, 0);
        chk("clr_beats_match_sat", cnt_b, 0);
        idle(10);

        // Reset in the middle of a word.
        send(8'hFF, 0);
        repeat (3) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        idle(3);
        send(8'hA5, 0);
        idle(10);

        // Randomized traffic with gaps, clears and occasional resets.
        for (int it = 0; it < 150; it++) begin
            keep = 1'($urandom_range(0, 1));
            send(8'($urandom), keep);
            if (!keep) begin
                for (int g = $urandom_range(0, 3); g > 0; g--) begin
                    clr_cnt_i = ($urandom_range(0, 9) == 0);
                    word_i = 8'($urandom);
                    cycle();
                end
                clr_cnt_i = 1'b0;
            end
            if (it % 37 == 36) begin
                word_valid_i = 1'b0;
                repeat ($urandom_range(0, 6)) cycle();
                rst = 1'b1;
                cycle();
                rst = 1'b0;
            end
        end
        idle(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
